button_debouncer: RTL and testbench

//  Conditions a raw, asynchronous push-button or switch input into a clean level and single-cycle edge

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/button_debouncer.sv | 108 ++++++++++
 tb/tb_button_debouncer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encodings are fixed so existing waveforms and probes still decode.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    localparam int unsigned SIM_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button: synchronizes it, requires STABLE_CYCLES equal samples,
// then updates a clean level and emits a one-cycle rise or fall pulse.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 120000,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    import button_debouncer_pkg::*;

    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("button_debouncer: STABLE_CYCLES must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_nx, rise_nx, fall_nx;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            level_out  <= level_nx;
            rise_pulse <= rise_nx;
            fall_pulse <= fall_nx;
        end
    end

    // Entering a CHK state counts the triggering sample as the first one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level_out;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nx = CHK_HIGH;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            CHK_HIGH: begin
                if (!s2) begin
                    state_nx = IDLE_LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE_HIGH;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_nx = CHK_LOW;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            CHK_LOW: begin
                if (s2) begin
                    state_nx = IDLE_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE_LOW;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: the driver queues expected pulse events by cycle number,
// a negedge monitor pops them and compares pulses and level.
`timescale 1ns/10ps
module tb_button_debouncer;

    import button_debouncer_pkg::*;

    localparam int unsigned LAT = 2 + SIM_STABLE_CYCLES;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic level_out, rise_pulse, fall_pulse;

    typedef struct {
        bit          is_rise;
        int unsigned cyc;
    } ev_t;

    ev_t         q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          exp_level = 1'b0;
    bit          prev_pulse = 1'b0;

    button_debouncer #(.STABLE_CYCLES(SIM_STABLE_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #0.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_ev(bit is_rise, int unsigned at);
        ev_t e;
        e.is_rise = is_rise;
        e.cyc     = at;
        q.push_back(e);
    endfunction

    // Monitor: decides expectations from the queue alone, then compares.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            bit er, ef;
            er = 1'b0;
            ef = 1'b0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_pulse", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (q[0].is_rise) begin
                    er = 1'b1;
                    exp_level = 1'b1;
                end else begin
                    ef = 1'b1;
                    exp_level = 1'b0;
                end
                void'(q.pop_front());
            end
            check("level_out", {31'd0, level_out}, {31'd0, exp_level});
            if (er || ef || rise_pulse || fall_pulse) begin
                check("rise_pulse", {31'd0, rise_pulse}, {31'd0, er});
                check("fall_pulse", {31'd0, fall_pulse}, {31'd0, ef});
                check("pulse_overlap", {31'd0, rise_pulse & fall_pulse}, 32'd0);
                check("pulse_length", {31'd0, prev_pulse & (rise_pulse | fall_pulse)}, 32'd0);
            end
            prev_pulse = rise_pulse | fall_pulse;
        end
    end

    task automatic chk_cleared(string tag);
        check(tag, {29'd0, level_out, rise_pulse, fall_pulse}, 32'd0);
    endtask

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset_flush();
        q.delete();
        exp_level  = 1'b0;
        prev_pulse = 1'b0;
    endtask

    initial begin
        int unsigned t0;
        rst    = 1'b1;
        btn_in = 1'b1;

        // 1: reset held with btn high
        repeat (5) begin
            @(negedge clk);
            chk_cleared("reset_hold");
        end

        // 2: release with btn already high, then hold
        rst = 1'b0;
        expect_ev(1'b1, cyc + LAT);
        wait_neg(12);

        // back to low
        btn_in = 1'b0;
        expect_ev(1'b0, cyc + LAT);
        wait_neg(10);

        // 3: high for STABLE_CYCLES-1 samples only
        btn_in = 1'b1;
        wait_neg(3);
        btn_in = 1'b0;
        wait_neg(10);

        // 4: bounce 1,0,1,0,1 then held high
        btn_in = 1'b1; wait_neg(1);
        btn_in = 1'b0; wait_neg(1);
        btn_in = 1'b1; wait_neg(1);
        btn_in = 1'b0; wait_neg(1);
        btn_in = 1'b1;
        expect_ev(1'b1, cyc + LAT);
        wait_neg(12);

        // 5: accepted high -> low
        btn_in = 1'b0;
        expect_ev(1'b0, cyc + LAT);
        wait_neg(12);

        // 6: reset during CHK_HIGH with cnt=2
        btn_in = 1'b1;
        wait_neg(4);
        #0.25 rst = 1'b1;
        do_reset_flush();
        #0.01 chk_cleared("reset_async_chk");
        repeat (3) begin
            @(negedge clk);
            chk_cleared("reset_hold_chk");
        end
        rst = 1'b0;
        t0 = cyc;
        expect_ev(1'b1, t0 + LAT);

        // reset landing inside the rise pulse
        wait_neg(LAT - 1);
        @(posedge clk);
        #0.2;
        check("rise_before_reset", {30'd0, rise_pulse, level_out}, 32'd3);
        rst = 1'b1;
        do_reset_flush();
        #0.01 chk_cleared("reset_async_pulse");
        repeat (2) begin
            @(negedge clk);
            chk_cleared("reset_hold_pulse");
        end
        btn_in = 1'b0;
        rst = 1'b0;
        wait_neg(10);

        while (q.size() > 0) begin
            check("pending_pulse", 32'd0, 32'd1);
            void'(q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
